// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite slave with a five-word register block: CTRL, STATUS, two scratch words and an ID constant.
// Write and read channels have independent two-state FSMs and can run at the same time.
module axi4l_reg_slave #(
    parameter bit [31:0] BASE_OFFSET      = 32'h80000000,
    parameter bit [31:0] BASE_OFFSET_MASK = 32'hFFFFFFE0,
    parameter bit [31:0] ID_VALUE         = 32'hA4100001
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] ctrl,
    input  logic [31:0] status
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t    w_state_reg, w_state_next;
    r_state_t    r_state_reg, r_state_next;
    logic        ready_en_reg;
    logic        aw_done_reg, aw_done_next;
    logic        w_done_reg, w_done_next;
    logic [31:0] awaddr_reg, awaddr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  wstrb_reg, wstrb_next;
    logic [1:0]  bresp_reg, bresp_next;
    logic [31:0] rdata_reg, rdata_next;
    logic [1:0]  rresp_reg, rresp_next;
    logic [31:0] ctrl_reg, scratch0_reg, scratch1_reg;

    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;

    function automatic logic [1:0] decode_resp(input logic [31:0] addr, input logic is_write);
        if ((addr & BASE_OFFSET_MASK) != BASE_OFFSET)
            return RESP_DECERR;
        case (addr[4:2])
            3'd0, 3'd2, 3'd3: return RESP_OKAY;
            3'd1, 3'd4:       return is_write ? RESP_SLVERR : RESP_OKAY;
            default:          return RESP_SLVERR;
        endcase
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val, input logic [31:0] new_val,
                                                input logic [3:0] strb);
        logic [31:0] m;
        m = old_val;
        for (int i = 0; i < 4; i++)
            if (strb[i]) m[i*8 +: 8] = new_val[i*8 +: 8];
        return m;
    endfunction

    // Ready outputs stay low during reset and for no longer: ready_en_reg rises on the first edge after release.
    assign awready = ready_en_reg && (w_state_reg == W_IDLE) && !aw_done_reg;
    assign wready  = ready_en_reg && (w_state_reg == W_IDLE) && !w_done_reg;
    assign arready = ready_en_reg && (r_state_reg == R_IDLE);
    assign bvalid  = (w_state_reg == W_RESP);
    assign rvalid  = (r_state_reg == R_DATA);
    assign bresp   = bresp_reg;
    assign rresp   = rresp_reg;
    assign rdata   = rdata_reg;
    assign ctrl    = ctrl_reg;

    assign wr_addr = aw_done_reg ? awaddr_reg : awaddr;
    assign wr_data = w_done_reg ? wdata_reg : wdata;
    assign wr_strb = w_done_reg ? wstrb_reg : wstrb;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en_reg <= 1'b0;
            w_state_reg  <= W_IDLE;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            awaddr_reg   <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            bresp_reg    <= '0;
            r_state_reg  <= R_IDLE;
            rdata_reg    <= '0;
            rresp_reg    <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            w_state_reg  <= w_state_next;
            aw_done_reg  <= aw_done_next;
            w_done_reg   <= w_done_next;
            awaddr_reg   <= awaddr_next;
            wdata_reg    <= wdata_next;
            wstrb_reg    <= wstrb_next;
            bresp_reg    <= bresp_next;
            r_state_reg  <= r_state_next;
            rdata_reg    <= rdata_next;
            rresp_reg    <= rresp_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        awaddr_next  = awaddr_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        bresp_next   = bresp_reg;
        wr_en        = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                if (awvalid && awready) begin
                    aw_done_next = 1'b1;
                    awaddr_next  = awaddr;
                end
                if (wvalid && wready) begin
                    w_done_next = 1'b1;
                    wdata_next  = wdata;
                    wstrb_next  = wstrb;
                end
                // Commit on the edge that completes the pair, whichever channel arrived last.
                if ((aw_done_reg || (awvalid && awready)) && (w_done_reg || (wvalid && wready))) begin
                    wr_en        = 1'b1;
                    bresp_next   = decode_resp(wr_addr, 1'b1);
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl_reg     <= '0;
            scratch0_reg <= '0;
            scratch1_reg <= '0;
        end else if (wr_en && decode_resp(wr_addr, 1'b1) == RESP_OKAY) begin
            case (wr_addr[4:2])
                3'd0:    ctrl_reg     <= merge_lanes(ctrl_reg, wr_data, wr_strb);
                3'd2:    scratch0_reg <= merge_lanes(scratch0_reg, wr_data, wr_strb);
                3'd3:    scratch1_reg <= merge_lanes(scratch1_reg, wr_data, wr_strb);
                default: ;
            endcase
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        rdata_next   = rdata_reg;
        rresp_next   = rresp_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (arvalid && arready) begin
                    r_state_next = R_DATA;
                    rresp_next   = decode_resp(araddr, 1'b0);
                    rdata_next   = '0;
                    if (decode_resp(araddr, 1'b0) == RESP_OKAY) begin
                        case (araddr[4:2])
                            3'd0:    rdata_next = ctrl_reg;
                            3'd1:    rdata_next = status;
                            3'd2:    rdata_next = scratch0_reg;
                            3'd3:    rdata_next = scratch1_reg;
                            3'd4:    rdata_next = ID_VALUE;
                            default: rdata_next = '0;
                        endcase
                    end
                end
            end
            R_DATA: begin
                if (rready) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Randomized and directed bench for axi4l_reg_slave, checked against a word-array model of the register map.
module tb_axi4l_reg_slave;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] ctrl;
    logic [31:0] status;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [0:4];

    axi4l_reg_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .ctrl(ctrl), .status(status)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] addr, input bit is_write);
        logic [31:0] word;
        if ((addr & 32'hFFFFFFE0) != 32'h80000000) return 2'b11;
        word = (addr - 32'h80000000) >> 2;
        if (word == 0 || word == 2 || word == 3) return 2'b00;
        if (word == 1 || word == 4) return is_write ? 2'b10 : 2'b00;
        return 2'b10;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int word;
        if (exp_resp(addr, 1) != 2'b00) return;
        word = int'((addr - 32'h80000000) >> 2);
        for (int b = 0; b < 4; b++)
            if (strb[b]) model[word][b*8 +: 8] = data[b*8 +: 8];
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [31:0] stat);
        int word;
        if (exp_resp(addr, 0) != 2'b00) return 32'h0;
        word = int'((addr - 32'h80000000) >> 2);
        if (word == 1) return stat;
        if (word == 4) return 32'hA4100001;
        return model[word];
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        int cyc;
        bit aw_got, w_got, aw_p, w_p;
        cyc = 0; aw_got = 0; w_got = 0;
        while (!(aw_got && w_got) && cyc < 64) begin
            @(negedge aclk);
            awaddr  = addr; wdata = data; wstrb = strb;
            awvalid = !aw_got && (cyc >= aw_dly);
            wvalid  = !w_got && (cyc >= w_dly);
            if (w_got && !aw_got) check("wready_after_w_capture", {31'b0, wready}, 32'd0);
            aw_p = awvalid && awready;
            w_p  = wvalid && wready;
            @(posedge aclk);
            aw_got |= aw_p; w_got |= w_p;
            cyc++;
        end
        @(negedge aclk);
        awvalid = 0; wvalid = 0;
        if (!(aw_got && w_got)) check("write_handshake_timeout", 32'd0, 32'd1);
        check("bvalid_after_write", {31'b0, bvalid}, 32'd1);
        resp = bresp;
        for (int i = 0; i < b_dly; i++) begin
            @(negedge aclk);
            check("bvalid_hold", {31'b0, bvalid}, 32'd1);
            check("bresp_hold", {30'b0, bresp}, {30'b0, resp});
            check("awready_in_resp", {31'b0, awready}, 32'd0);
        end
        bready = 1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 0;
        check("bvalid_drop", {31'b0, bvalid}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        bit got, p;
        cyc = 0; got = 0;
        while (!got && cyc < 64) begin
            @(negedge aclk);
            araddr = addr; arvalid = 1;
            p = arready;
            @(posedge aclk);
            got = p;
            cyc++;
        end
        @(negedge aclk);
        arvalid = 0;
        if (!got) check("read_handshake_timeout", 32'd0, 32'd1);
        check("rvalid_after_ar", {31'b0, rvalid}, 32'd1);
        data = rdata; resp = rresp;
        for (int i = 0; i < r_dly; i++) begin
            @(negedge aclk);
            check("rvalid_hold", {31'b0, rvalid}, 32'd1);
            check("rdata_hold", rdata, data);
        end
        rready = 1;
        @(posedge aclk);
        @(negedge aclk);
        rready = 0;
        check("rvalid_drop", {31'b0, rvalid}, 32'd0);
    endtask

    initial begin
        logic [31:0] d, addr, data;
        logic [1:0]  r;
        logic [3:0]  strb;

        aresetn = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 0; araddr = 0; arvalid = 0; rready = 0; status = 0;
        for (int i = 0; i < 5; i++) model[i] = 0;

        repeat (3) @(negedge aclk);
        check("rst_awready", {31'b0, awready}, 32'd0);
        check("rst_wready", {31'b0, wready}, 32'd0);
        check("rst_arready", {31'b0, arready}, 32'd0);
        check("rst_bvalid", {31'b0, bvalid}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_ctrl", ctrl, 32'd0);
        aresetn = 1;
        @(posedge aclk); #1;
        check("release_awready", {31'b0, awready}, 32'd1);
        check("release_wready", {31'b0, wready}, 32'd1);
        check("release_arready", {31'b0, arready}, 32'd1);

        // Basic write/readback of SCRATCH0
        do_write(32'h80000008, 32'hDEADBEEF, 4'hF, 0, 0, 0, r);
        model_write(32'h80000008, 32'hDEADBEEF, 4'hF);
        check("scratch0_bresp", {30'b0, r}, 32'd0);
        do_read(32'h80000008, 0, d, r);
        check("scratch0_rdata", d, 32'hDEADBEEF);
        check("scratch0_rresp", {30'b0, r}, 32'd0);
        $display("WR/RD scratch0 data=%h resp=%0d", d, r);

        // Partial byte-lane write of SCRATCH1
        do_write(32'h8000000C, 32'h11223344, 4'hF, 0, 0, 1, r);
        do_write(32'h8000000C, 32'hAABBCCDD, 4'b0101, 0, 0, 0, r);
        model_write(32'h8000000C, 32'h11223344, 4'hF);
        model_write(32'h8000000C, 32'hAABBCCDD, 4'b0101);
        do_read(32'h8000000C, 2, d, r);
        check("scratch1_strb", d, 32'h11BB33DD);
        $display("WR/RD scratch1 strb data=%h", d);

        // W leads AW by 3 cycles, bready held off 5 cycles
        do_write(32'h80000008, 32'h0BADF00D, 4'hF, 3, 0, 5, r);
        model_write(32'h80000008, 32'h0BADF00D, 4'hF);
        check("w_first_bresp", {30'b0, r}, 32'd0);
        do_read(32'h80000008, 0, d, r);
        check("w_first_rdata", d, 32'h0BADF00D);
        $display("WR w-first scratch0 data=%h", d);

        // ID, RO write, unmapped and decode miss
        do_read(32'h80000010, 0, d, r);
        check("id_rdata", d, 32'hA4100001);
        check("id_rresp", {30'b0, r}, 32'd0);
        do_write(32'h80000010, 32'h12345678, 4'hF, 0, 0, 0, r);
        check("id_write_bresp", {30'b0, r}, 32'd2);
        do_read(32'h80000010, 0, d, r);
        check("id_after_write", d, 32'hA4100001);
        do_read(32'h80000014, 0, d, r);
        check("unmapped_rresp", {30'b0, r}, 32'd2);
        check("unmapped_rdata", d, 32'd0);
        do_read(32'h00000000, 0, d, r);
        check("decerr_rresp", {30'b0, r}, 32'd3);
        check("decerr_rdata", d, 32'd0);
        $display("RD id/unmapped/miss checked");

        // Simultaneous write and read of CTRL, prior value 0
        @(negedge aclk);
        awaddr = 32'h80000000; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 32'h80000000; arvalid = 1;
        check("sim_all_ready", {29'b0, awready, wready, arready}, 32'd7);
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        model[0] = 32'h5;
        check("sim_ctrl_out", ctrl, 32'h5);
        check("sim_rdata_old", rdata, 32'h0);
        check("sim_bvalid", {31'b0, bvalid}, 32'd1);
        check("sim_rvalid", {31'b0, rvalid}, 32'd1);
        bready = 1; rready = 1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 0; rready = 0;
        do_read(32'h80000000, 0, d, r);
        check("sim_ctrl_next_read", d, 32'h5);
        $display("WR+RD ctrl concurrent new=%h", d);

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0)
                addr = $urandom;
            else
                addr = 32'h80000000 | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r);
                check("rand_bresp", {30'b0, r}, {30'b0, exp_resp(addr, 1)});
                model_write(addr, data, strb);
                $display("WR addr=%h data=%h strb=%h resp=%0d", addr, data, strb, r);
            end else begin
                status = $urandom;
                do_read(addr, $urandom_range(0, 2), d, r);
                check("rand_rresp", {30'b0, r}, {30'b0, exp_resp(addr, 0)});
                check("rand_rdata", d, model_read(addr, status));
                $display("RD addr=%h data=%h resp=%0d", addr, d, r);
            end
            check("rand_ctrl", ctrl, model[0]);
        end

        // Reset during a pending read response and a half-captured write
        do_write(32'h80000000, 32'hCAFE0001, 4'hF, 0, 0, 0, r);
        model_write(32'h80000000, 32'hCAFE0001, 4'hF);
        @(negedge aclk);
        araddr = 32'h80000000; arvalid = 1;
        awaddr = 32'h80000008; awvalid = 1;
        @(posedge aclk);
        @(negedge aclk);
        arvalid = 0; awvalid = 0;
        check("pre_rst_rvalid", {31'b0, rvalid}, 32'd1);
        aresetn = 0;
        #1;
        check("mid_rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("mid_rst_ctrl", ctrl, 32'd0);
        check("mid_rst_arready", {31'b0, arready}, 32'd0);
        for (int i = 0; i < 5; i++) model[i] = 0;
        @(negedge aclk);
        aresetn = 1;
        @(posedge aclk); #1;
        check("post_rst_arready", {31'b0, arready}, 32'd1);
        check("post_rst_awready", {31'b0, awready}, 32'd1);
        repeat (3) begin
            @(negedge aclk);
            check("post_rst_no_bvalid", {31'b0, bvalid}, 32'd0);
            check("post_rst_no_rvalid", {31'b0, rvalid}, 32'd0);
        end
        do_read(32'h80000000, 0, d, r);
        check("post_rst_ctrl_read", d, 32'd0);
        $display("RST mid-transaction ctrl=%h", d);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
